// File: rtl/ftdi_tx_mass_pkg.sv
// Shared types and helpers for the command-driven bulk TX generator.
package ftdi_tx_mass_pkg;

  // Pattern modes carried in bits [1:0] of the command mode byte.
  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_DEC   = 2'd1,
    MODE_CONST = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic {
    S_HDR = 1'b0,
    S_GEN = 1'b1
  } state_e;

  // Widest beat (TX_EW=4) and widest length field (LEN_BYTES=8).
  localparam int MAX_BW = 16;
  localparam int MAX_LW = 64;

  // Command frame is one mode byte followed by the length field.
  function automatic int cmd_bytes(input int len_bytes);
    return 1 + len_bytes;
  endfunction

  // Byte enables for a beat of bw lanes with rem bytes still to send:
  // all lanes when rem >= bw, otherwise the low rem lanes.
  function automatic logic [MAX_BW-1:0] keep_mask(input logic [MAX_LW-1:0] rem,
                                                 input int unsigned      bw);
    logic [MAX_BW-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < MAX_BW; k++) begin
      if ((k < bw) && (64'(k) < rem)) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ftdi_tx_pattern_beat.sv
// Combinational content of one TX beat: data per lane, byte enables, last flag.
module ftdi_tx_pattern_beat
  import ftdi_tx_mass_pkg::*;
#(
  parameter int         TX_EW      = 2,
  parameter int         LEN_BYTES  = 4,
  parameter logic [7:0] CONST_BYTE = 8'h5A
) (
  input  logic [1:0]                    mode,
  input  logic [8*LEN_BYTES-1:0]        base,
  input  logic [8*LEN_BYTES-1:0]        rem,
  output logic [8*(1<<TX_EW)-1:0]       tdata,
  output logic [(1<<TX_EW)-1:0]         tkeep,
  output logic                          tlast
);

  localparam int BW = 1 << TX_EW;
  localparam int LW = 8 * LEN_BYTES;

  assign tkeep = BW'(keep_mask(MAX_LW'(rem), BW));
  assign tlast = (rem <= LW'(BW));

  for (genvar k = 0; k < BW; k++) begin : g_lane
    logic [7:0] idx;
    logic [7:0] val;

    // Byte index wraps mod 256, so only the low byte of base+k matters.
    assign idx = 8'(base + LW'(k));

    // Lane value by pattern mode; the reserved mode falls back to incrementing.
    always_comb begin
      case (mode)
        MODE_DEC:   val = ~idx;
        MODE_CONST: val = CONST_BYTE;
        default:    val = idx;
      endcase
    end

    assign tdata[8*k +: 8] = tkeep[k] ? val : 8'h00;
  end

endmodule

// File: rtl/ftdi_tx_mass_gen.sv
// Bulk TX traffic generator: parses a mode+length command from the RX byte
// stream and emits that many pattern bytes as registered AXI-stream beats.
module ftdi_tx_mass_gen
  import ftdi_tx_mass_pkg::*;
#(
  parameter int         TX_EW      = 2,
  parameter int         LEN_BYTES  = 4,
  parameter logic [7:0] CONST_BYTE = 8'h5A
) (
  input  logic                        clk,
  input  logic                        rstn,
  output logic                        rx_tready,
  input  logic                        rx_tvalid,
  input  logic [7:0]                  rx_tdata,
  input  logic                        tx_tready,
  output logic                        tx_tvalid,
  output logic [8*(1<<TX_EW)-1:0]     tx_tdata,
  output logic [(1<<TX_EW)-1:0]       tx_tkeep,
  output logic                        tx_tlast,
  output logic                        busy,
  output logic [15:0]                 cmd_cnt,
  output logic                        err
);

  localparam int BW        = 1 << TX_EW;
  localparam int LW        = 8 * LEN_BYTES;
  localparam int CMD_BYTES = cmd_bytes(LEN_BYTES);
  localparam int HDR_LAST  = CMD_BYTES - 1;

  state_e          state, next_state;
  logic [3:0]      hdr_idx;
  logic [1:0]      mode_q;
  logic [LW-1:0]   len_acc;
  logic [LW-1:0]   len_full;
  logic [LW-1:0]   i_p0;
  logic [LW-1:0]   rem_p0;
  logic [LW-1:0]   pat_base;
  logic [LW-1:0]   pat_rem;
  logic            hdr_fire;
  logic            hdr_last;
  logic            tx_fire;
  logic [8*BW-1:0] pat_tdata;
  logic [BW-1:0]   pat_tkeep;
  logic            pat_tlast;

  assign rx_tready = (state == S_HDR);
  assign busy      = (state == S_GEN);

  // Full length value, merging the byte arriving now as the final header byte.
  always_comb begin
    len_full = len_acc;
    for (int j = 0; j < LEN_BYTES; j++) begin
      if (hdr_idx == 4'(j + 1)) len_full[8*j +: 8] = rx_tdata;
    end
  end

  // Next state, handshakes and the beat to load next (first beat or successor).
  always_comb begin
    next_state = state;
    hdr_fire   = rx_tvalid && (state == S_HDR);
    hdr_last   = hdr_fire && (hdr_idx == 4'(HDR_LAST));
    tx_fire    = tx_tvalid && tx_tready;
    pat_base   = i_p0 + LW'(BW);
    pat_rem    = rem_p0 - LW'(BW);
    case (state)
      S_HDR: begin
        pat_base = '0;
        pat_rem  = len_full;
        if (hdr_last && (len_full != '0)) next_state = S_GEN;
      end
      S_GEN: begin
        if (tx_fire && tx_tlast) next_state = S_HDR;
      end
      default: next_state = S_HDR;
    endcase
  end

  ftdi_tx_pattern_beat #(
    .TX_EW      (TX_EW),
    .LEN_BYTES  (LEN_BYTES),
    .CONST_BYTE (CONST_BYTE)
  ) u_beat (
    .mode  (mode_q),
    .base  (pat_base),
    .rem   (pat_rem),
    .tdata (pat_tdata),
    .tkeep (pat_tkeep),
    .tlast (pat_tlast)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_HDR;
    else       state <= next_state;
  end

  // Header index, registered TX beat, command counter and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdr_idx   <= '0;
      tx_tvalid <= 1'b0;
      tx_tdata  <= '0;
      tx_tkeep  <= '0;
      tx_tlast  <= 1'b0;
      cmd_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      if (hdr_fire) begin
        if (hdr_last) begin
          hdr_idx <= '0;
          if (mode_q == MODE_RSVD) err <= 1'b1;
          if (len_full == '0) begin
            cmd_cnt <= cmd_cnt + 16'd1;
          end else begin
            tx_tvalid <= 1'b1;
            tx_tdata  <= pat_tdata;
            tx_tkeep  <= pat_tkeep;
            tx_tlast  <= pat_tlast;
          end
        end else begin
          hdr_idx <= hdr_idx + 4'd1;
        end
      end
      if (tx_fire) begin
        if (tx_tlast) begin
          tx_tvalid <= 1'b0;
          tx_tdata  <= '0;
          tx_tkeep  <= '0;
          tx_tlast  <= 1'b0;
          cmd_cnt   <= cmd_cnt + 16'd1;
        end else begin
          tx_tdata  <= pat_tdata;
          tx_tkeep  <= pat_tkeep;
          tx_tlast  <= pat_tlast;
        end
      end
    end
  end

  // Header payload capture and beat position; no reset needed, every
  // command rewrites these before they are used.
  always_ff @(posedge clk) begin
    if (hdr_fire && !hdr_last) begin
      if (hdr_idx == 4'd0) mode_q <= rx_tdata[1:0];
      for (int j = 0; j < LEN_BYTES; j++) begin
        if (hdr_idx == 4'(j + 1)) len_acc[8*j +: 8] <= rx_tdata;
      end
    end
    if (hdr_last) begin
      i_p0   <= '0;
      rem_p0 <= len_full;
    end else if (tx_fire && !tx_tlast) begin
      i_p0   <= i_p0 + LW'(BW);
      rem_p0 <= rem_p0 - LW'(BW);
    end
  end

endmodule

// File: tb/tb_ftdi_tx_mass_gen.sv
// Randomized self-checking bench for ftdi_tx_mass_gen against a byte-stream model.
module tb_ftdi_tx_mass_gen;

  localparam int BW        = 4;
  localparam int LEN_BYTES = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_tready;
  logic        rx_tvalid = 1'b0;
  logic [7:0]  rx_tdata = 8'h00;
  logic        tx_tready = 1'b0;
  logic        tx_tvalid;
  logic [31:0] tx_tdata;
  logic [3:0]  tx_tkeep;
  logic        tx_tlast;
  logic        busy;
  logic [15:0] cmd_cnt;
  logic        err;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk   = 0;
  int    n_pass  = 0;
  int    exp_cnt = 0;
  logic  exp_err = 1'b0;

  always #5 clk = ~clk;

  ftdi_tx_mass_gen #(.TX_EW(2), .LEN_BYTES(LEN_BYTES), .CONST_BYTE(8'h5A)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_tready (rx_tready),
    .rx_tvalid (rx_tvalid),
    .rx_tdata  (rx_tdata),
    .tx_tready (tx_tready),
    .tx_tvalid (tx_tvalid),
    .tx_tdata  (tx_tdata),
    .tx_tkeep  (tx_tkeep),
    .tx_tlast  (tx_tlast),
    .busy      (busy),
    .cmd_cnt   (cmd_cnt),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Byte n of a command stream in the given mode.
  function automatic logic [7:0] ref_byte(input logic [7:0] mode, input int idx);
    case (mode[1:0])
      2'd1:    return ~8'(idx % 256);
      2'd2:    return 8'h5A;
      default: return 8'(idx % 256);
    endcase
  endfunction

  // Cut the byte stream of a command into BW-wide beats.
  task automatic build_expect(input logic [7:0] mode, input int len);
    int nb;
    beat_t b;
    exp_q.delete();
    nb = (len + BW - 1) / BW;
    for (int n = 0; n < nb; n++) begin
      b.data = '0;
      b.keep = '0;
      for (int k = 0; k < BW; k++) begin
        if (n * BW + k < len) begin
          b.data[8*k +: 8] = ref_byte(mode, n * BW + k);
          b.keep[k]        = 1'b1;
        end
      end
      b.last = (n == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  // Drive one command frame; returns at the falling edge after the last byte.
  task automatic send_hdr(input logic [7:0] mode, input int len);
    logic [7:0] hdr[LEN_BYTES+1];
    hdr[0] = mode;
    for (int j = 0; j < LEN_BYTES; j++) hdr[j+1] = 8'(len >> (8 * j));
    if (mode[1:0] == 2'd3) exp_err = 1'b1;
    for (int b = 0; b <= LEN_BYTES; b++) begin
      @(negedge clk);
      if (b == 0) chk("hdr_rx_tready", rx_tready, 1);
      rx_tvalid = 1'b1;
      rx_tdata  = hdr[b];
    end
    @(negedge clk);
    rx_tvalid = 1'b0;
    rx_tdata  = 8'h00;
  endtask

  task automatic run_cmd(input logic [7:0] mode, input int len, input int pct);
    int  cyc;
    logic fire;
    build_expect(mode, len);
    send_hdr(mode, len);
    if (len == 0) begin
      exp_cnt++;
      chk("zl_cmd_cnt", cmd_cnt, exp_cnt);
      chk("zl_rx_tready", rx_tready, 1);
      for (int c = 0; c < 3; c++) begin
        chk("zl_no_valid", tx_tvalid, 0);
        @(negedge clk);
      end
      return;
    end
    chk("lat_valid", tx_tvalid, 1);
    chk("gen_busy", busy, 1);
    chk("gen_rx_tready", rx_tready, 0);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      chk("beat_valid", tx_tvalid, 1);
      chk("beat_data", tx_tdata, exp_q[0].data);
      chk("beat_keep", tx_tkeep, exp_q[0].keep);
      chk("beat_last", tx_tlast, exp_q[0].last);
      tx_tready = ($urandom_range(99) < pct);
      fire = tx_tvalid && tx_tready;
      @(posedge clk);
      @(negedge clk);
      if (fire) void'(exp_q.pop_front());
      cyc++;
    end
    chk("beats_left", exp_q.size(), 0);
    tx_tready = 1'b0;
    exp_cnt++;
    chk("end_valid", tx_tvalid, 0);
    chk("end_busy", busy, 0);
    chk("end_rx_tready", rx_tready, 1);
    chk("end_cmd_cnt", cmd_cnt, exp_cnt);
    chk("end_err", err, exp_err);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_tready"}, rx_tready, 1);
    chk({tag, "_tvalid"}, tx_tvalid, 0);
    chk({tag, "_tdata"}, tx_tdata, 0);
    chk({tag, "_tkeep"}, tx_tkeep, 0);
    chk({tag, "_tlast"}, tx_tlast, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmd_cnt"}, cmd_cnt, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rstn = 1'b1;

    run_cmd(8'h00, 5, 100);
    run_cmd(8'h00, 0, 100);
    run_cmd(8'h00, 260, 50);
    run_cmd(8'h01, 3, 100);
    run_cmd(8'h02, 4, 100);
    run_cmd(8'h03, 1, 100);

    for (int r = 0; r < 8; r++) begin
      logic [7:0] m;
      m = {6'($urandom), 2'($urandom_range(0, 2))};
      run_cmd(m, $urandom_range(0, 50), $urandom_range(30, 100));
    end

    // Abort partway through a 10-beat command.
    send_hdr(8'h00, 40);
    tx_tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_beat3_data", tx_tdata, 32'h0B0A0908);
    tx_tready = 1'b0;
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("abort");
    exp_cnt = 0;
    exp_err = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_cmd(8'h00, 40, 70);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
